branch_cc_ctrl: RTL and testbench
=================================

# branch_cc_ctrl

Branch resolution controller for the LC-3b pipeline. It owns the architectural condition codes and counts in-flight CC-setting instructions. It accepts one branch at a time, holds the branch until every older CC write has retired, then drives the NZP comparator and issues a one-cycle redirect/flush when the branch is taken. It sits between decode (branch/CC-issue side) and writeback (CC update side).

## Interface
- MAX_INFLIGHT, default 3: maximum outstanding CC-setting instructions. Counter width is $clog2(MAX_INFLIGHT+1).
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  reset; synchronous, active-low.
- cc_issue  in  1  a CC-setting instruction enters the pipeline this cycle.
- cc_wb_valid  in  1  a CC-setting instruction writes back this cycle.
- cc_wb_value  in  lc3b_nzp  new CC value, qualified by cc_wb_valid.
- br_valid  in  1  decode presents a conditional branch.
- br_nzp  in  lc3b_nzp  nzp field of the branch.
- br_target  in  lc3b_word  branch target PC.
- br_ready  out  1  branch accepted when br_valid && br_ready.
- stall_issue  out  1  decode must not assert cc_issue or br_valid.
- redirect_valid  out  1  one-cycle pulse: branch taken.
- redirect_pc  out  lc3b_word  target, valid with redirect_valid.
- flush  out  1  squash younger instructions; equals redirect_valid.
- cc  out  lc3b_nzp  architectural condition codes.
- taken_cnt  out  16  count of taken branches, wraps.

## Operation
- Pending counter:
  - +1 on cc_issue, -1 on cc_wb_valid.
  - Both in the same cycle: no change.
  - Never exceeds MAX_INFLIGHT and never goes below 0. Out-of-range events are clamped; bench asserts they never occur.
- cc register: loads cc_wb_value on every cc_wb_valid, including when pending==0.
- FSM states:
  - IDLE:
    - br_ready=1.
    - On accept, capture br_nzp/br_target.
    - Next state is RESOLVE if the next pending count is 0, otherwise WAIT.
  - WAIT:
    - br_ready=0.
    - Move to RESOLVE in the first cycle the registered pending==0.
    - cc already holds the final value by then.
  - RESOLVE:
    - br_en = comparator(captured nzp, cc).
    - If br_en: redirect_valid=flush=1, redirect_pc=captured target, taken_cnt+1.
    - Always return to IDLE.
- stall_issue = (pending==MAX_INFLIGHT) || (state!=IDLE). Blocking issue while a branch is held keeps younger CC writes out of the count.
- br_nzp=000: never taken. Still passes through RESOLVE with no redirect.
- Reset values:
  - state=IDLE, pending=0, cc=3'b010 (Z).
  - taken_cnt=0, redirect_valid=flush=0, redirect_pc=0.
  - Captured regs=0.
- Reset mid-operation: a held branch is discarded and no redirect is produced. The first cycle after rst_n rises behaves as IDLE.

## Timing
- Accept at cycle T with pending 0 after T: redirect at T+1.
- Accept at T with pending k>0: redirect one cycle after the cycle in which the k-th cc_wb_valid is registered.
  - Example: k=1, writeback at T+2 → RESOLVE at T+3.
- No forwarding. A writeback in the accept cycle counts toward the pending decision but not toward the compare until registered.
- redirect_valid/flush are single-cycle pulses with no backpressure. Branch throughput is at most one per 2 cycles.
- All outputs are registered or decoded from state/registers only. No combinational path from inputs to outputs except none.

## Structure
- lc3b_types package: lc3b_nzp, lc3b_word, and a branch-controller state enum (IDLE/WAIT/RESOLVE). The CC reset constant goes here.
- Sub-module: instantiate the team's existing nzpcomp combinational comparator for br_en. Do not re-derive the match logic.
- Pending counter, cc register, and FSM live in branch_cc_ctrl itself.

## Test plan
- Reset, no pending:
  - Stimulus: branch nzp=010, target 0x3000.
  - Response: redirect_valid at T+1 with redirect_pc=0x3000; taken_cnt=1.
- One CC write pending:
  - Stimulus: cc_issue at T-1; branch nzp=100 accepted at T; cc_wb_valid with 100 at T+3.
  - Response: WAIT through T+3, redirect at T+4.
- Same setup, writeback value 001:
  - Response: no redirect; br_ready back to 1 at T+5; taken_cnt unchanged.
- Fill to MAX_INFLIGHT=3:
  - Stimulus: cc_issue three times; then cc_issue together with cc_wb_valid in one cycle.
  - Response: stall_issue=1 while pending is 3; simultaneous issue+writeback leaves pending unchanged.
- Never-taken branch:
  - Stimulus: br_nzp=000 with cc=010.
  - Response: no redirect, state returns to IDLE.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during WAIT with pending=2.
  - Response: next cycle pending=0, cc=010, br_ready=1, no redirect ever issued for the discarded branch.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types for the branch/condition-code controller: condition
// code and word types, the controller state encoding and the CC reset value.
package lc3b_types;

  typedef logic [2:0]  lc3b_nzp;
  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    BR_IDLE    = 2'd0,
    BR_WAIT    = 2'd1,
    BR_RESOLVE = 2'd2
  } br_state_t;

  // Condition codes come out of reset as Z.
  localparam lc3b_nzp CC_RESET = 3'b010;

endpackage

// File: rtl/nzpcomp.sv
// NZP comparator: a branch is enabled when any nzp bit it tests is set in cc.
module nzpcomp
  import lc3b_types::*;
(
  input  lc3b_nzp nzp,
  input  lc3b_nzp cc,
  output logic    br_en
);

  assign br_en = |(nzp & cc);

endmodule

// File: rtl/branch_cc_ctrl.sv
// Branch resolution controller: owns the architectural condition codes,
// counts in-flight CC-setting instructions, holds one branch until all older
// CC writes have retired, then compares and issues a one-cycle redirect/flush.
//
// Handshake: a branch transfers on a cycle where br_valid && br_ready. br_ready
// is a decode of the registered state only (high in BR_IDLE), so it never
// depends on br_valid. Decode must keep cc_issue and br_valid low while
// stall_issue is high; the controller does not re-check this.
module branch_cc_ctrl
  import lc3b_types::*;
#(
  parameter int MAX_INFLIGHT = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      cc_issue,
  input  logic      cc_wb_valid,
  input  lc3b_nzp   cc_wb_value,
  input  logic      br_valid,
  input  lc3b_nzp   br_nzp,
  input  lc3b_word  br_target,
  output logic      br_ready,
  output logic      stall_issue,
  output logic      redirect_valid,
  output lc3b_word  redirect_pc,
  output logic      flush,
  output lc3b_nzp   cc,
  output logic [15:0] taken_cnt,
  output br_state_t state_dbg
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] PEND_MAX = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] PEND_ONE = CW'(1);

  br_state_t     state, state_next;
  logic [CW-1:0] pending, pending_next;
  lc3b_nzp       cc_q;
  lc3b_nzp       cap_nzp;
  lc3b_word      cap_target;
  logic [15:0]   taken_q;
  logic          accept;
  logic          br_en;
  logic          redirect;

  // Comparator sees only registered values: captured nzp and current cc.
  nzpcomp u_nzpcomp (
    .nzp   (cap_nzp),
    .cc    (cc_q),
    .br_en (br_en)
  );

  assign accept   = br_valid && br_ready;
  assign redirect = (state == BR_RESOLVE) && br_en;

  // Pending count after this cycle's issue/writeback; saturates at both ends.
  always_comb begin
    pending_next = pending;
    unique case ({cc_issue, cc_wb_valid})
      2'b10:   if (pending != PEND_MAX) pending_next = pending + PEND_ONE;
      2'b01:   if (pending != '0)       pending_next = pending - PEND_ONE;
      default: pending_next = pending;
    endcase
  end

  // Next-state logic: resolve once the count seen after this cycle is zero,
  // which is also when the last older writeback has landed in cc.
  always_comb begin
    state_next = state;
    unique case (state)
      BR_IDLE: begin
        if (accept) begin
          state_next = (pending_next == '0) ? BR_RESOLVE : BR_WAIT;
        end
      end
      BR_WAIT: begin
        if (pending_next == '0) state_next = BR_RESOLVE;
      end
      BR_RESOLVE: begin
        state_next = BR_IDLE;
      end
      default: begin
        state_next = BR_IDLE;
      end
    endcase
  end

  // State, counter, cc, captured branch and taken counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BR_IDLE;
      pending    <= '0;
      cc_q       <= CC_RESET;
      cap_nzp    <= '0;
      cap_target <= '0;
      taken_q    <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      if (cc_wb_valid) cc_q <= cc_wb_value;
      if (accept) begin
        cap_nzp    <= br_nzp;
        cap_target <= br_target;
      end
      if (redirect) taken_q <= taken_q + 16'd1;
    end
  end

  assign br_ready       = (state == BR_IDLE);
  assign stall_issue    = (pending == PEND_MAX) || (state != BR_IDLE);
  assign redirect_valid = redirect;
  assign flush          = redirect;
  assign redirect_pc    = redirect ? cap_target : '0;
  assign cc             = cc_q;
  assign taken_cnt      = taken_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_branch_cc_ctrl.sv
// Testbench for branch_cc_ctrl: directed scenarios followed by a randomized
// run against a branch-level reference model.
module tb_branch_cc_ctrl;
  import lc3b_types::*;

  localparam int MAXI = 3;

  logic        clk;
  logic        rst_n;
  logic        cc_issue;
  logic        cc_wb_valid;
  lc3b_nzp     cc_wb_value;
  logic        br_valid;
  lc3b_nzp     br_nzp;
  lc3b_word    br_target;
  logic        br_ready;
  logic        stall_issue;
  logic        redirect_valid;
  lc3b_word    redirect_pc;
  logic        flush;
  lc3b_nzp     cc;
  logic [15:0] taken_cnt;
  br_state_t   state_dbg;

  int checks;
  int failures;

  branch_cc_ctrl #(.MAX_INFLIGHT(MAXI)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cc_issue       (cc_issue),
    .cc_wb_valid    (cc_wb_valid),
    .cc_wb_value    (cc_wb_value),
    .br_valid       (br_valid),
    .br_nzp         (br_nzp),
    .br_target      (br_target),
    .br_ready       (br_ready),
    .stall_issue    (stall_issue),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .cc             (cc),
    .taken_cnt      (taken_cnt),
    .state_dbg      (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs for one cycle (set at a falling edge), return at the next
  // falling edge so outputs reflect the state after that cycle's rising edge.
  task automatic drive(input logic iss, input logic wb, input lc3b_nzp wbv,
                       input logic bv, input lc3b_nzp bn, input lc3b_word bt);
    cc_issue    = iss;
    cc_wb_valid = wb;
    cc_wb_value = wbv;
    br_valid    = bv;
    br_nzp      = bn;
    br_target   = bt;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 16'h0000);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    idle();
    rst_n = 1'b1;
    checks++; if (br_ready !== 1'b1) begin failures++; $display("FAIL reset_br_ready got=%b exp=1", br_ready); end
    checks++; if (stall_issue !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_issue); end
    checks++; if (cc !== 3'b010) begin failures++; $display("FAIL reset_cc got=%b exp=010", cc); end
    checks++; if (taken_cnt !== 16'd0) begin failures++; $display("FAIL reset_taken got=%0d exp=0", taken_cnt); end
    checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0 || redirect_pc !== 16'h0)
      begin failures++; $display("FAIL reset_redirect got=%b/%b/%h exp=0/0/0000", redirect_valid, flush, redirect_pc); end
    checks++; if (state_dbg !== BR_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=IDLE", state_dbg); end
  endtask

  task automatic test_taken_no_pending();
    drive(1'b0, 1'b0, 3'b000, 1'b1, 3'b010, 16'h3000);   // accept at T
    checks++; if (redirect_valid !== 1'b1 || flush !== 1'b1) begin failures++; $display("FAIL nopend_redirect got=%b/%b exp=1/1", redirect_valid, flush); end
    checks++; if (redirect_pc !== 16'h3000) begin failures++; $display("FAIL nopend_pc got=%h exp=3000", redirect_pc); end
    checks++; if (br_ready !== 1'b0 || stall_issue !== 1'b1) begin failures++; $display("FAIL nopend_hold got=%b/%b exp=0/1", br_ready, stall_issue); end
    idle();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL nopend_pulse got=%b exp=0", redirect_valid); end
    checks++; if (taken_cnt !== 16'd1) begin failures++; $display("FAIL nopend_taken got=%0d exp=1", taken_cnt); end
    checks++; if (br_ready !== 1'b1) begin failures++; $display("FAIL nopend_ready got=%b exp=1", br_ready); end
  endtask

  // One older CC write outstanding; writeback lands at T+3.
  task automatic test_one_pending(input lc3b_nzp wbv, input logic exp_taken);
    logic [15:0] base;
    base = taken_cnt;
    drive(1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 16'h0000);     // T-1 issue
    drive(1'b0, 1'b0, 3'b000, 1'b1, 3'b100, 16'h1234);     // T accept
    for (int c = 1; c <= 3; c++) begin
      checks++; if (state_dbg !== BR_WAIT || br_ready !== 1'b0 || redirect_valid !== 1'b0)
        begin failures++; $display("FAIL pend_wait c=%0d got=%0d/%b/%b exp=WAIT/0/0", c, state_dbg, br_ready, redirect_valid); end
      if (c < 3) idle();
    end
    drive(1'b0, 1'b1, wbv, 1'b0, 3'b000, 16'h0000);        // T+3 writeback
    checks++; if (redirect_valid !== exp_taken) begin failures++; $display("FAIL pend_redirect wbv=%b got=%b exp=%b", wbv, redirect_valid, exp_taken); end
    checks++; if (redirect_pc !== (exp_taken ? 16'h1234 : 16'h0000)) begin failures++; $display("FAIL pend_pc got=%h", redirect_pc); end
    checks++; if (cc !== wbv) begin failures++; $display("FAIL pend_cc got=%b exp=%b", cc, wbv); end
    idle();                                               // now T+5
    checks++; if (br_ready !== 1'b1) begin failures++; $display("FAIL pend_ready got=%b exp=1", br_ready); end
    checks++; if (taken_cnt !== base + 16'(exp_taken)) begin failures++; $display("FAIL pend_taken got=%0d exp=%0d", taken_cnt, base + 16'(exp_taken)); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < MAXI; i++) begin
      checks++; if (stall_issue !== 1'b0) begin failures++; $display("FAIL fill_nostall i=%0d got=%b exp=0", i, stall_issue); end
      drive(1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 16'h0000);
    end
    checks++; if (stall_issue !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", stall_issue); end
    drive(1'b1, 1'b1, 3'b001, 1'b0, 3'b000, 16'h0000);     // issue+writeback
    checks++; if (stall_issue !== 1'b1) begin failures++; $display("FAIL fill_simul got=%b exp=1", stall_issue); end
    drive(1'b0, 1'b1, 3'b100, 1'b0, 3'b000, 16'h0000);
    checks++; if (stall_issue !== 1'b0) begin failures++; $display("FAIL fill_drain got=%b exp=0", stall_issue); end
    drive(1'b0, 1'b1, 3'b001, 1'b0, 3'b000, 16'h0000);
    drive(1'b0, 1'b1, 3'b010, 1'b0, 3'b000, 16'h0000);
    // Count is back to zero: a branch must resolve the very next cycle.
    drive(1'b0, 1'b0, 3'b000, 1'b1, 3'b010, 16'h0BEE);
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0BEE) begin failures++; $display("FAIL fill_empty got=%b/%h exp=1/0bee", redirect_valid, redirect_pc); end
    idle();
  endtask

  task automatic test_never_taken();
    logic [15:0] base;
    base = taken_cnt;
    checks++; if (cc !== 3'b010) begin failures++; $display("FAIL never_cc got=%b exp=010", cc); end
    drive(1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 16'h4444);
    checks++; if (state_dbg !== BR_RESOLVE || redirect_valid !== 1'b0) begin failures++; $display("FAIL never_resolve got=%0d/%b exp=RESOLVE/0", state_dbg, redirect_valid); end
    idle();
    checks++; if (state_dbg !== BR_IDLE || taken_cnt !== base) begin failures++; $display("FAIL never_idle got=%0d/%0d exp=IDLE/%0d", state_dbg, taken_cnt, base); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 16'h0000);
    drive(1'b1, 1'b1, 3'b100, 1'b0, 3'b000, 16'h0000);     // cc<=100, count 1
    drive(1'b1, 1'b0, 3'b000, 1'b1, 3'b111, 16'h7777);     // count 2, accept
    checks++; if (state_dbg !== BR_WAIT) begin failures++; $display("FAIL mid_wait got=%0d exp=WAIT", state_dbg); end
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    checks++; if (br_ready !== 1'b1 || stall_issue !== 1'b0 || cc !== 3'b010)
      begin failures++; $display("FAIL mid_reset got=%b/%b/%b exp=1/0/010", br_ready, stall_issue, cc); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL mid_noredir c=%0d got=%b exp=0", c, redirect_valid); end
      idle();
    end
    // Pending was cleared: a fresh branch resolves without waiting.
    drive(1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 16'h0001);
    checks++; if (state_dbg !== BR_RESOLVE) begin failures++; $display("FAIL mid_pend0 got=%0d exp=RESOLVE", state_dbg); end
    idle();
  endtask

  // Randomized traffic against a branch-level model: a held branch waits for
  // the older writebacks counted at acceptance, then compares against cc.
  task automatic test_random();
    int          m_pend, m_older;
    bit          m_held, m_resolve;
    lc3b_nzp     m_cc, m_nzp, wbv, bn;
    lc3b_word    m_tgt, bt, e_pc;
    logic [15:0] m_taken;
    bit          e_redir, e_stall, iss, wb, bv;
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    m_pend = 0; m_older = 0; m_held = 0; m_resolve = 0;
    m_cc = 3'b010; m_nzp = 0; m_tgt = 0; m_taken = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      e_stall = (m_pend == MAXI) || m_held;
      e_redir = m_resolve && ((m_nzp & m_cc) != 3'b000);
      e_pc    = e_redir ? m_tgt : 16'h0000;
      checks++; if (br_ready !== !m_held) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, br_ready, !m_held); end
      checks++; if (stall_issue !== e_stall) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, stall_issue, e_stall); end
      checks++; if (redirect_valid !== e_redir || flush !== e_redir) begin failures++; $display("FAIL rnd_redirect cyc=%0d got=%b/%b exp=%b", cyc, redirect_valid, flush, e_redir); end
      checks++; if (redirect_pc !== e_pc) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, redirect_pc, e_pc); end
      checks++; if (cc !== m_cc) begin failures++; $display("FAIL rnd_cc cyc=%0d got=%b exp=%b", cyc, cc, m_cc); end
      checks++; if (taken_cnt !== m_taken) begin failures++; $display("FAIL rnd_taken cyc=%0d got=%0d exp=%0d", cyc, taken_cnt, m_taken); end
      iss = !e_stall && ($urandom_range(0, 2) == 0);
      wb  = (m_pend > 0 || iss) && ($urandom_range(0, 2) == 0);
      bv  = !e_stall && ($urandom_range(0, 3) == 0);
      wbv = 3'($urandom_range(1, 7));
      bn  = 3'($urandom_range(0, 7));
      bt  = 16'($urandom);
      drive(iss, wb, wbv, bv, bn, bt);
      // Model update for the cycle just clocked.
      m_pend = m_pend + int'(iss) - int'(wb);
      if (wb) m_cc = wbv;
      if (m_resolve) begin
        if (e_redir) m_taken = m_taken + 16'd1;
        m_held = 0;
        m_resolve = 0;
      end else if (m_held) begin
        if (wb) m_older = m_older - 1;
        if (m_older == 0) m_resolve = 1;
      end else if (bv) begin
        m_held = 1;
        m_nzp = bn;
        m_tgt = bt;
        m_older = m_pend;
        m_resolve = (m_pend == 0);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    cc_issue = 1'b0; cc_wb_valid = 1'b0; cc_wb_value = '0;
    br_valid = 1'b0; br_nzp = '0; br_target = '0;
    @(negedge clk);
    test_reset();
    test_taken_no_pending();
    test_one_pending(3'b100, 1'b1);
    test_one_pending(3'b001, 1'b0);
    test_fill();
    test_never_taken();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
